// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: state encoding,
// default parameter values and the hardwired-zero register number.
package hazard_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } hz_state_e;

  localparam int BOOT_CYCLES_DEF  = 4;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int CNT_W_DEF        = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts Inc pulses, sticks at all-ones,
// and clears only on asynchronous reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Inc,
  output logic [W-1:0] Count
);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Count <= '0;
    end else if (Inc && (Count != '1)) begin
      Count <= Count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Central pipeline control for the 5-stage MIPS core: boot flush, load-use
// stalls, MEM-resolved branch flushes and a halt/drain handshake.
module pipeline_hazard_sequencer
  import hazard_pkg::*;
#(
  parameter int BOOT_CYCLES  = BOOT_CYCLES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_Rt,
  input  logic             M_BranchTaken,
  input  logic             HaltReq,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic             EXMEM_Flush,
  output logic             HaltAck,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int CYC_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int DW      = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [DW-1:0] BOOT_INIT  = DW'(BOOT_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);

  hz_state_e     state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          lu, br;
  logic          stall_inc, flush_inc;

  assign lu = EX_MemRead && (EX_Rt != REG_ZERO) &&
              ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));
  assign br = M_BranchTaken;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= BOOT;
      cnt_q   <= BOOT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWrite     = 1'b0;
    IFID_Write  = 1'b0;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    EXMEM_Flush = 1'b0;
    HaltAck     = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state_q)
      BOOT: begin
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RUN: begin
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        // A taken branch squashes the stalled instruction, so it wins over LU
        if (br) begin
          IFID_Flush  = 1'b1;
          IDEX_Flush  = 1'b1;
          EXMEM_Flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (lu) begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
          stall_inc  = 1'b1;
        end
        if (HaltReq) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_INIT;
        end
      end
      DRAIN: begin
        IFID_Write = 1'b1;
        IFID_Flush = 1'b1;
        if (br) begin
          PCWrite     = 1'b1;
          IDEX_Flush  = 1'b1;
          EXMEM_Flush = 1'b1;
          flush_inc   = 1'b1;
        end else if (lu) begin
          IFID_Write = 1'b0;
          IFID_Flush = 1'b0;
          IDEX_Flush = 1'b1;
          stall_inc  = 1'b1;
        end
        // Stalled cycles retire nothing, so they do not count toward the drain
        if (!HaltReq) begin
          state_d = RUN;
        end else if (!(lu && !br)) begin
          if (cnt_q == '0) state_d = HALTED;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      HALTED: begin
        HaltAck    = 1'b1;
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
        if (!HaltReq) state_d = RUN;
      end
      default: begin
        state_d     = BOOT;
        cnt_d       = BOOT_INIT;
        IFID_Flush  = 1'b1;
        IDEX_Flush  = 1'b1;
        EXMEM_Flush = 1'b1;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (stall_inc),
    .Count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .Inc   (flush_inc),
    .Count (FlushCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer; a second instance with a
// 2-bit counter width exercises counter saturation.
module tb_pipeline_hazard_sequencer;

  logic        Clk;
  logic        Reset;
  logic [4:0]  ID_Rs, ID_Rt, EX_Rt;
  logic        ID_UsesRt, EX_MemRead, M_BranchTaken, HaltReq;
  logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, HaltAck;
  logic [15:0] StallCount, FlushCount;
  logic        s_PCWrite, s_IFID_Write, s_IFID_Flush, s_IDEX_Flush, s_EXMEM_Flush, s_HaltAck;
  logic [1:0]  s_StallCount, s_FlushCount;
  logic [5:0]  outs;

  int vectors    = 0;
  int miscompares = 0;

  // Output bit order: PCWrite IFID_Write IFID_Flush IDEX_Flush EXMEM_Flush HaltAck
  localparam logic [5:0] O_BOOT   = 6'b001110;
  localparam logic [5:0] O_RUN    = 6'b110000;
  localparam logic [5:0] O_STALL  = 6'b000100;
  localparam logic [5:0] O_BR     = 6'b111110;
  localparam logic [5:0] O_DRAIN  = 6'b011000;
  localparam logic [5:0] O_HALTED = 6'b001101;

  assign outs = {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, HaltAck};

  pipeline_hazard_sequencer dut (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .M_BranchTaken(M_BranchTaken), .HaltReq(HaltReq),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
    .EXMEM_Flush(EXMEM_Flush), .HaltAck(HaltAck), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  pipeline_hazard_sequencer #(.CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .M_BranchTaken(M_BranchTaken), .HaltReq(HaltReq),
    .PCWrite(s_PCWrite), .IFID_Write(s_IFID_Write), .IFID_Flush(s_IFID_Flush),
    .IDEX_Flush(s_IDEX_Flush), .EXMEM_Flush(s_EXMEM_Flush), .HaltAck(s_HaltAck),
    .StallCount(s_StallCount), .FlushCount(s_FlushCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Window opens just after the falling edge; the rising edge lies 4 ns later
  task automatic next_cycle();
    @(negedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
    EX_MemRead = 1'b0; EX_Rt = 5'd0; M_BranchTaken = 1'b0;
  endtask

  task automatic set_lu();
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8; ID_UsesRt = 1'b0; ID_Rt = 5'd0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; HaltReq = 1'b0;
    idle_inputs();
    #2;
    vectors++;
    if (outs !== O_BOOT) begin miscompares++; $display("FAIL reset_async_outs: got %b want %b", outs, O_BOOT); end
    repeat (2) @(posedge Clk);
    next_cycle();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      #1;
      vectors++;
      if (outs !== O_BOOT) begin miscompares++; $display("FAIL boot_cycle%0d: got %b want %b", i + 1, outs, O_BOOT); end
    end
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL boot_exit_run: got %b want %b", outs, O_RUN); end
    vectors++;
    if (StallCount !== 16'd0 || FlushCount !== 16'd0) begin
      miscompares++; $display("FAIL reset_counters: got %0d/%0d want 0/0", StallCount, FlushCount);
    end
  endtask

  task automatic test_load_use();
    next_cycle();
    set_lu();
    #1;
    vectors++;
    if (outs !== O_STALL) begin miscompares++; $display("FAIL lu_rs_stall: got %b want %b", outs, O_STALL); end
    next_cycle();
    idle_inputs();
    #1;
    vectors++;
    if (StallCount !== 16'd1) begin miscompares++; $display("FAIL lu_stall_count: got %0d want 1", StallCount); end
    next_cycle();
    EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL lu_r0_nostall: got %b want %b", outs, O_RUN); end
    next_cycle();
    EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rt = 5'd8; ID_Rs = 5'd3; ID_UsesRt = 1'b0;
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL lu_rt_unused_nostall: got %b want %b", outs, O_RUN); end
    next_cycle();
    ID_UsesRt = 1'b1;
    #1;
    vectors++;
    if (outs !== O_STALL) begin miscompares++; $display("FAIL lu_rt_stall: got %b want %b", outs, O_STALL); end
    next_cycle();
    idle_inputs();
    #1;
    vectors++;
    if (StallCount !== 16'd2) begin miscompares++; $display("FAIL lu_stall_count2: got %0d want 2", StallCount); end
  endtask

  task automatic test_branch_priority();
    next_cycle();
    set_lu();
    M_BranchTaken = 1'b1;
    #1;
    vectors++;
    if (outs !== O_BR) begin miscompares++; $display("FAIL br_over_lu_outs: got %b want %b", outs, O_BR); end
    next_cycle();
    idle_inputs();
    #1;
    vectors++;
    if (FlushCount !== 16'd1 || StallCount !== 16'd2) begin
      miscompares++; $display("FAIL br_over_lu_counts: got %0d/%0d want 1/2", FlushCount, StallCount);
    end
  endtask

  task automatic test_halt();
    next_cycle();
    HaltReq = 1'b1;
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL halt_req_cycle: got %b want %b", outs, O_RUN); end
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      #1;
      vectors++;
      if (outs !== O_DRAIN) begin miscompares++; $display("FAIL drain_k+%0d: got %b want %b", i, outs, O_DRAIN); end
    end
    for (int i = 5; i <= 6; i++) begin
      next_cycle();
      #1;
      vectors++;
      if (outs !== O_HALTED) begin miscompares++; $display("FAIL halted_k+%0d: got %b want %b", i, outs, O_HALTED); end
    end
    HaltReq = 1'b0;
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL halt_resume: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_halt_lu();
    next_cycle();
    HaltReq = 1'b1;
    next_cycle();
    set_lu();
    #1;
    vectors++;
    if (outs !== O_STALL) begin miscompares++; $display("FAIL drain_lu_outs: got %b want %b", outs, O_STALL); end
    next_cycle();
    idle_inputs();
    for (int i = 2; i <= 5; i++) begin
      if (i > 2) next_cycle();
      #1;
      vectors++;
      if (outs !== O_DRAIN) begin miscompares++; $display("FAIL drain_lu_k+%0d: got %b want %b", i, outs, O_DRAIN); end
    end
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_HALTED) begin miscompares++; $display("FAIL drain_lu_halted_k+6: got %b want %b", outs, O_HALTED); end
    vectors++;
    if (StallCount !== 16'd3) begin miscompares++; $display("FAIL drain_lu_count: got %0d want 3", StallCount); end
    HaltReq = 1'b0;
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL drain_lu_resume: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_drain_branch();
    next_cycle();
    HaltReq = 1'b1;
    next_cycle();
    M_BranchTaken = 1'b1;
    #1;
    vectors++;
    if (outs !== O_BR) begin miscompares++; $display("FAIL drain_br_outs: got %b want %b", outs, O_BR); end
    next_cycle();
    idle_inputs();
    for (int i = 2; i <= 4; i++) begin
      if (i > 2) next_cycle();
      #1;
      vectors++;
      if (outs !== O_DRAIN) begin miscompares++; $display("FAIL drain_br_k+%0d: got %b want %b", i, outs, O_DRAIN); end
    end
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_HALTED) begin miscompares++; $display("FAIL drain_br_halted_k+5: got %b want %b", outs, O_HALTED); end
    vectors++;
    if (FlushCount !== 16'd2) begin miscompares++; $display("FAIL drain_br_count: got %0d want 2", FlushCount); end
    HaltReq = 1'b0;
    next_cycle();
    // Abort: request for one edge, then withdraw during DRAIN
    HaltReq = 1'b1;
    next_cycle();
    HaltReq = 1'b0;
    #1;
    vectors++;
    if (outs !== O_DRAIN) begin miscompares++; $display("FAIL abort_drain: got %b want %b", outs, O_DRAIN); end
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL abort_run: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_reset_in_drain();
    next_cycle();
    HaltReq = 1'b1;
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_DRAIN) begin miscompares++; $display("FAIL rst_drain1: got %b want %b", outs, O_DRAIN); end
    next_cycle();
    Reset = 1'b0;
    HaltReq = 1'b0;
    #1;
    vectors++;
    if (outs !== O_BOOT) begin miscompares++; $display("FAIL rst_drain_async: got %b want %b", outs, O_BOOT); end
    vectors++;
    if (StallCount !== 16'd0 || FlushCount !== 16'd0) begin
      miscompares++; $display("FAIL rst_drain_counters: got %0d/%0d want 0/0", StallCount, FlushCount);
    end
    next_cycle();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cycle();
      #1;
      vectors++;
      if (outs !== O_BOOT) begin miscompares++; $display("FAIL rst_reboot_cycle%0d: got %b want %b", i + 1, outs, O_BOOT); end
    end
    next_cycle();
    #1;
    vectors++;
    if (outs !== O_RUN) begin miscompares++; $display("FAIL rst_reboot_run: got %b want %b", outs, O_RUN); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      set_lu();
    end
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      idle_inputs();
      M_BranchTaken = 1'b1;
    end
    next_cycle();
    idle_inputs();
    #1;
    vectors++;
    if (StallCount !== 16'd5 || FlushCount !== 16'd5) begin
      miscompares++; $display("FAIL sat_wide_counts: got %0d/%0d want 5/5", StallCount, FlushCount);
    end
    vectors++;
    if (s_StallCount !== 2'd3 || s_FlushCount !== 2'd3) begin
      miscompares++; $display("FAIL sat_narrow_counts: got %0d/%0d want 3/3", s_StallCount, s_FlushCount);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_halt();
    test_halt_lu();
    test_drain_branch();
    test_reset_in_drain();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
